mem_access_ctrl: RTL and testbench

// - Initiator side of the word-wide data memory port (address/writeData/memWrite/memRead/readData).
// - Accepts byte/half/word loads and stores from the CPU core on a req/done handshake and drives the

---
 rtl/mem_access_ctrl.sv | 151 +++++++++++++++
 tb/tb_mem_access_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Byte/half/word load-store initiator for a word-only data memory; sub-word stores use read-modify-write.
// Optional BOUNDS_CHECK_EN rejects addresses whose bits above the word index are non-zero.
module mem_access_ctrl #(
   parameter int unsigned ADDR_W = 7
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [1:0]  size,
   input  logic        uns,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] rdata,
   output logic [31:0] mem_address,
   output logic [31:0] mem_writeData,
   output logic        mem_memWrite,
   output logic        mem_memRead,
   input  logic [31:0] mem_readData
);

   typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

   state_t            state_q, state_d;
   logic              we_q, we_d;
   logic [1:0]        size_q, size_d;
   logic              uns_q, uns_d;
   logic [ADDR_W+1:0] addr_q, addr_d;
   logic [31:0]       wword_q, wword_d;
   logic              err_q, err_d;
   logic [31:0]       rdata_q, rdata_d;

   logic              oob;
   logic              misaligned;
   logic [7:0]        byte_v;
   logic [15:0]       half_v;
   logic [31:0]       load_v;
   logic [31:0]       merged_v;

`ifdef BOUNDS_CHECK_EN
   assign oob = |addr[31:ADDR_W+2];
`else
   logic unused_hi;
   assign oob       = 1'b0;
   assign unused_hi = ^addr[31:ADDR_W+2];
`endif

   assign misaligned = (size == 2'b11)
                     | ((size == 2'b01) & addr[0])
                     | ((size == 2'b10) & (addr[1:0] != 2'b00));

   always_comb begin
      byte_v = mem_readData[{addr_q[1:0], 3'b000} +: 8];
      half_v = addr_q[1] ? mem_readData[31:16] : mem_readData[15:0];
      case (size_q)
         2'b00:   load_v = {{24{~uns_q & byte_v[7]}}, byte_v};
         2'b01:   load_v = {{16{~uns_q & half_v[15]}}, half_v};
         default: load_v = mem_readData;
      endcase
      // wword_q still holds the right-aligned store data while in RD
      merged_v = mem_readData;
      if (size_q == 2'b00)
         merged_v[{addr_q[1:0], 3'b000} +: 8] = wword_q[7:0];
      else if (addr_q[1])
         merged_v[31:16] = wword_q[15:0];
      else
         merged_v[15:0] = wword_q[15:0];
   end

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      size_d  = size_q;
      uns_d   = uns_q;
      addr_d  = addr_q;
      wword_d = wword_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               we_d    = we;
               size_d  = size;
               uns_d   = uns;
               addr_d  = addr[ADDR_W+1:0];
               wword_d = wdata;
               err_d   = misaligned | oob;
               if (misaligned | oob)
                  state_d = DONE;
               else if (we && (size == 2'b10))
                  state_d = WR;
               else
                  state_d = RD;
            end
         end
         RD: begin
            if (we_q) begin
               wword_d = merged_v;
               state_d = WR;
            end else begin
               rdata_d = load_v;
               state_d = DONE;
            end
         end
         WR:      state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         size_q  <= '0;
         uns_q   <= 1'b0;
         addr_q  <= '0;
         wword_q <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         addr_q  <= addr_d;
         wword_q <= wword_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   // memory strobes decode from state only, so they are quiet in IDLE and immediately on reset
   always_comb begin
      busy          = (state_q != IDLE);
      done          = (state_q == DONE);
      err           = (state_q == DONE) & err_q;
      rdata         = rdata_q;
      mem_memRead   = (state_q == RD);
      mem_memWrite  = (state_q == WR);
      mem_address   = '0;
      mem_writeData = '0;
      if ((state_q == RD) || (state_q == WR))
         mem_address[ADDR_W-1:0] = addr_q[ADDR_W+1:2];
      if (state_q == WR)
         mem_writeData = wword_q;
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl with a behavioural word memory attached to the mem_* port.
module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        req;
   logic        we;
   logic [1:0]  size;
   logic        uns;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        busy;
   logic        done;
   logic        err;
   logic [31:0] rdata;
   logic [31:0] mem_address;
   logic [31:0] mem_writeData;
   logic        mem_memWrite;
   logic        mem_memRead;
   logic [31:0] mem_readData;

   logic [31:0] mem [0:127] = '{default: '0};

   typedef struct {
      int unsigned id;
      logic        is_load;
      logic        exp_err;
      logic [31:0] exp_rdata;
      int unsigned start;
      int unsigned lat;
      int unsigned nwr;
      int unsigned nrd;
      int unsigned wr0;
      int unsigned rd0;
   } sb_t;

   sb_t         sb[$];
   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;
   int unsigned cyc    = 0;
   int unsigned wr_cnt = 0;
   int unsigned rd_cnt = 0;
   int unsigned txn_id = 0;

   mem_access_ctrl #(.ADDR_W(7)) dut (
      .clk          (clk),
      .reset        (reset),
      .req          (req),
      .we           (we),
      .size         (size),
      .uns          (uns),
      .addr         (addr),
      .wdata        (wdata),
      .busy         (busy),
      .done         (done),
      .err          (err),
      .rdata        (rdata),
      .mem_address  (mem_address),
      .mem_writeData(mem_writeData),
      .mem_memWrite (mem_memWrite),
      .mem_memRead  (mem_memRead),
      .mem_readData (mem_readData)
   );

   always #5 clk = ~clk;

   assign mem_readData = mem[mem_address[6:0]];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_memWrite) mem[mem_address[6:0]] <= mem_writeData;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   always @(negedge clk) begin
      sb_t e;
      if (mem_memWrite) wr_cnt++;
      if (mem_memRead)  rd_cnt++;
      if (done) begin
         if (sb.size() == 0) begin
            check("spurious_done", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            check($sformatf("t%0d_err", e.id), {31'd0, err}, {31'd0, e.exp_err});
            if (e.is_load && !e.exp_err)
               check($sformatf("t%0d_rdata", e.id), rdata, e.exp_rdata);
            check($sformatf("t%0d_latency", e.id), cyc - e.start + 1, e.lat);
            check($sformatf("t%0d_nwrite", e.id), wr_cnt - e.wr0, e.nwr);
            check($sformatf("t%0d_nread", e.id), rd_cnt - e.rd0, e.nrd);
         end
      end
   end

   task automatic start_txn(input logic w, input logic [1:0] sz, input logic u,
                            input logic [31:0] a, input logic [31:0] d,
                            input logic e_err, input logic [31:0] e_rd,
                            input int unsigned lat, input int unsigned nwr, input int unsigned nrd);
      sb_t e;
      @(negedge clk);
      req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = d;
      @(posedge clk);
      #1;
      // other inputs are don't-care after the accept edge; scramble them
      req = 1'b0; we = $urandom_range(1, 0); size = 2'($urandom); uns = $urandom_range(1, 0);
      addr = $urandom; wdata = $urandom;
      e.id = txn_id; e.is_load = ~w; e.exp_err = e_err; e.exp_rdata = e_rd;
      e.start = cyc; e.lat = lat; e.nwr = nwr; e.nrd = nrd; e.wr0 = wr_cnt; e.rd0 = rd_cnt;
      sb.push_back(e);
      txn_id++;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 20; i++) begin
         if (sb.size() == 0) break;
         @(posedge clk);
      end
      if (sb.size() != 0) begin
         check("done_timeout", sb.size(), 0);
         sb.delete();
      end
   endtask

   task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic e_err, input logic [31:0] e_rd,
                        input int unsigned lat, input int unsigned nwr, input int unsigned nrd);
      start_txn(w, sz, u, a, d, e_err, e_rd, lat, nwr, nrd);
      wait_done();
   endtask

   initial begin
      int unsigned wr_snap;
      logic [6:0]  idx;
      logic [31:0] dat;
      bit          seen;

      reset = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; uns = 1'b0; addr = '0; wdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_mem_address", mem_address, 32'd0);
      reset = 1'b0;

      // addr 0x200 sets a bit above the word index
`ifdef BOUNDS_CHECK_EN
      issue(1'b1, 2'b10, 1'b0, 32'h0000_0200, 32'hCAFE_F00D, 1'b1, 32'h0, 1, 0, 0);
      check("oob_mem0", mem[0], 32'h0);
`else
      issue(1'b1, 2'b10, 1'b0, 32'h0000_0200, 32'hCAFE_F00D, 1'b0, 32'h0, 2, 1, 0);
      check("wrap_mem0", mem[0], 32'hCAFE_F00D);
`endif

      issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0, 2, 1, 0);
      check("ws_mem4", mem[4], 32'hDEAD_BEEF);
      issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD_BEEF, 2, 0, 1);
      issue(1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFF_FF55, 1'b0, 32'h0, 3, 1, 1);
      check("bs_mem4", mem[4], 32'hDEAD_55EF);

      issue(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 1'b0, 32'hFFFF_FFDE, 2, 0, 1);
      issue(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b0, 32'h0000_00DE, 2, 0, 1);
      issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b0, 32'hFFFF_DEAD, 2, 0, 1);
      issue(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 1'b0, 32'h0000_0055, 2, 0, 1);
      issue(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 1'b0, 32'h0000_55EF, 2, 0, 1);
      issue(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 1'b0, 32'hFFFF_FFEF, 2, 0, 1);

      issue(1'b1, 2'b10, 1'b0, 32'h14, 32'h89AB_CDEF, 1'b0, 32'h0, 2, 1, 0);
      issue(1'b1, 2'b01, 1'b0, 32'h16, 32'hFFFF_1234, 1'b0, 32'h0, 3, 1, 1);
      check("hs_mem5", mem[5], 32'h1234_CDEF);
      issue(1'b1, 2'b01, 1'b0, 32'h14, 32'h0000_8001, 1'b0, 32'h0, 3, 1, 1);
      check("hs_lo_mem5", mem[5], 32'h1234_8001);

      issue(1'b1, 2'b01, 1'b0, 32'h21, 32'h0000_ABCD, 1'b1, 32'h0, 1, 0, 0);
      issue(1'b0, 2'b10, 1'b0, 32'h22, 32'h0, 1'b1, 32'h0, 1, 0, 0);
      issue(1'b1, 2'b11, 1'b0, 32'h20, 32'h1111_2222, 1'b1, 32'h0, 1, 0, 0);
      check("err_mem8", mem[8], 32'h0);

      // req held during DONE must not start another access
      start_txn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEAD_55EF, 2, 0, 1);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done) begin seen = 1'b1; break; end
      end
      check("donereq_seen", {31'd0, seen}, 32'd1);
      req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h40; wdata = 32'h1111_1111;
      @(posedge clk);
      @(negedge clk);
      req = 1'b0;
      check("donereq_idle", {31'd0, busy}, 32'd0);
      @(negedge clk);
      check("donereq_still_idle", {31'd0, busy}, 32'd0);
      check("donereq_mem16", mem[16], 32'h0);
      sb.delete();

      // reset while in RD of a byte store
      @(negedge clk);
      req = 1'b1; we = 1'b1; size = 2'b00; uns = 1'b0; addr = 32'h11; wdata = 32'h0000_00AA;
      @(posedge clk);
      #1;
      req = 1'b0;
      wr_snap = wr_cnt;
      @(negedge clk);
      check("rmw_in_rd", {31'd0, mem_memRead}, 32'd1);
      reset = 1'b1;
      #1;
      check("rmwrst_busy", {31'd0, busy}, 32'd0);
      check("rmwrst_done", {31'd0, done}, 32'd0);
      check("rmwrst_read", {31'd0, mem_memRead}, 32'd0);
      check("rmwrst_write", {31'd0, mem_memWrite}, 32'd0);
      check("rmwrst_addr", mem_address, 32'd0);
      check("rmwrst_wdata", mem_writeData, 32'd0);
      check("rmwrst_rdata", rdata, 32'd0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("rmwrst_nwrite", wr_cnt - wr_snap, 0);
      check("rmwrst_mem4", mem[4], 32'hDEAD_55EF);

      for (int unsigned k = 0; k < 6; k++) begin
         idx = 7'($urandom_range(127, 20));
         dat = $urandom;
         issue(1'b1, 2'b10, 1'b0, {23'd0, idx, 2'b00}, dat, 1'b0, 32'h0, 2, 1, 0);
         issue(1'b0, 2'b10, 1'b0, {23'd0, idx, 2'b00}, 32'h0, 1'b0, dat, 2, 0, 1);
      end

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
